// File: rtl/l2_request_arbiter_pkg.sv
// Shared definitions for the L2 request arbiter: core count, core index width and the L2 request packet.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package l2_request_arbiter_pkg;
  localparam int CORE_INDEX_WIDTH = $clog2(`NUM_CORES);
  localparam int L2_ID_WIDTH      = 4;

  typedef enum logic [2:0] {
    L2REQ_LOAD,
    L2REQ_STORE,
    L2REQ_LOAD_SYNC,
    L2REQ_STORE_SYNC,
    L2REQ_FLUSH,
    L2REQ_IINVALIDATE,
    L2REQ_DINVALIDATE
  } l2req_packet_type_t;

  typedef struct packed {
    l2req_packet_type_t            packet_type;
    logic [CORE_INDEX_WIDTH-1:0]   core;
    logic [L2_ID_WIDTH-1:0]        id;
    logic [31:0]                   adress;
    logic [31:0]                   data;
    logic [3:0]                    store_mask;
  } l2req_packet_t;
endpackage

// File: rtl/l2_arb_fifo.sv
// Per-core request queue: power-of-two ring buffer of whole L2 request packets.
module l2_arb_fifo
  import l2_request_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enqueue_en,
  input  logic          dequeue_en,
  input  l2req_packet_t value_i,
  output l2req_packet_t value_o,
  output logic          full,
  output logic          empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  l2req_packet_t      storage [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_enq;
  logic               do_deq;

  assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enqueue_en & ~full;
  assign do_deq = dequeue_en & ~empty;
  assign value_o = storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_enq) storage[wr_ptr] <= value_i;
  end
endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter in front of l2_cache: per-core queues, rotating pick, one registered grant per cycle.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = `NUM_CORES,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] l2i_request_valid,
  input  l2req_packet_t             l2i_request [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] l2_ready,
  output logic                      arb_request_valid,
  output l2req_packet_t             arb_request,
  input  logic                      arb_ready
);
  localparam int IDX_W = CORE_INDEX_WIDTH;

  l2req_packet_t             fifo_out [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] fifo_full;
  logic [NUM_REQUESTERS-1:0] fifo_empty;
  logic [NUM_REQUESTERS-1:0] enq;
  logic [NUM_REQUESTERS-1:0] deq;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_found;
  logic                      load;
  int                        cand;
  l2req_packet_t             sel_pkt;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQUESTERS - 1) ? '0 : IDX_W'(int'(idx) + 1);
  endfunction

  assign l2_ready = ~fifo_full;
  assign enq      = l2i_request_valid & l2_ready;

  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_queue
    l2_arb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .enqueue_en (enq[i]),
      .dequeue_en (deq[i]),
      .value_i    (l2i_request[i]),
      .value_o    (fifo_out[i]),
      .full       (fifo_full[i]),
      .empty      (fifo_empty[i])
    );
  end

  // First non-empty queue at or after rr_ptr, wrapping upward.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQUESTERS;
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign load = grant_found & (~arb_request_valid | arb_ready);

  always_comb begin
    deq = '0;
    if (load) deq[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_pkt      = fifo_out[grant_idx];
    sel_pkt.core = grant_idx;
  end

  // Output register boundary: control is reset, the packet payload is not.
  always_ff @(posedge clk) begin
    if (!reset) begin
      arb_request_valid <= 1'b0;
      rr_ptr            <= '0;
    end else if (load) begin
      arb_request_valid <= 1'b1;
      rr_ptr            <= rr_next(grant_idx);
    end else if (arb_ready) begin
      arb_request_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) arb_request <= sel_pkt;
  end
endmodule
